// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, fixed-latency (1-cycle) instruction memory
// requests, and a 2-entry return queue presented to decode over a valid/ready handshake.
// Taken-branch redirects flush queued entries and drop the in-flight response.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc_plus4,
  input  logic              if_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target
);

  logic                   run_q;
  logic [ADDR_W-1:0]      pc_q;
  logic                   inflight_q;
  logic [1:0]             count_q;
  logic                   wptr_q;
  logic                   rptr_q;
  logic [1:0][31:0]       instr_q;
  logic [1:0][ADDR_W-1:0] pcp4_q;

  logic              pop;
  logic              push;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] target;

  // Handshake, request throttle and head-of-queue presentation.
  always_comb begin
    if_valid    = (count_q != 2'd0);
    pop         = if_valid & if_ready;
    // A response landing in a redirect cycle belongs to the old path and is dropped.
    push        = inflight_q & ~br_taken;
    // Entries held plus the one in flight, less the one leaving now, must leave a free slot.
    occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    imem_req    = run_q & ~br_taken & (occupancy < 3'd2);
    imem_addr   = pc_q;
    target      = br_target & ~(ADDR_W'(3));
    if_instr    = if_valid ? instr_q[rptr_q] : 32'h0;
    if_pc_plus4 = if_valid ? pcp4_q[rptr_q] : '0;
  end

  // PC, in-flight tracking and queue state; a redirect wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      instr_q    <= '0;
      pcp4_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= imem_req;
      if (br_taken) begin
        pc_q <= target;
      end else if (imem_req) begin
        pc_q <= pc_q + ADDR_W'(4);
      end
      if (br_taken) begin
        count_q <= 2'd0;
        wptr_q  <= 1'b0;
        rptr_q  <= 1'b0;
      end else begin
        if (push) begin
          instr_q[wptr_q] <= imem_rdata;
          // No request is issued in a redirect cycle, so in the response cycle pc_q is
          // exactly the requested address + 4.
          pcp4_q[wptr_q]  <= pc_q;
          wptr_q          <= ~wptr_q;
        end
        if (pop) begin
          rptr_q <= ~rptr_q;
        end
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // The request throttle must keep the two-entry queue from ever overflowing.
  queue_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == 2'd2)));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the single-issue MIPS datapath.
- Generates the PC, issues word reads to a fixed-latency instruction memory, and buffers returned words in a 2-entry queue.
- Presents instructions to the decode stage over a valid/ready handshake; decode splits the opcode field out to the control decoder.
- Accepts taken-branch redirects, with flush of queued and in-flight fetches.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  ADDR_W  word-aligned read address; low 2 bits always 0
- imem_rdata  input  32  read data, valid exactly 1 cycle after an imem_req cycle
- if_valid  output  1  head entry of the queue is valid
- if_instr  output  32  instruction word at the queue head
- if_pc_plus4  output  ADDR_W  fetch address of the head entry + 4
- if_ready  input  1  decode accepts the head entry this cycle
- br_taken  input  1  one-cycle redirect pulse from the branch resolve logic (Branch & Zero)
- br_target  input  ADDR_W  redirect address; bits [1:0] ignored and forced to 0

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, queue count=0, inflight=0, run=0.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc_plus4=0.
  - run sets on the first clk edge after release, so imem_req stays 0 in that first cycle.
- Handshake:
  - pop = if_valid & if_ready.
  - if_instr and if_pc_plus4 must hold stable while if_valid=1 and if_ready=0.
  - Entries leave strictly in fetch order, with no loss or duplication.
- Request rule:
  - imem_req = run & ~br_taken & (count + inflight - pop < 2).
  - imem_addr = pc, combinational from the pc register.
  - On a req cycle, pc <= pc+4 (mod 2^ADDR_W, so 0xFFFF_FFFC wraps to 0) and inflight <= 1.
  - Otherwise inflight <= 0.
- Response:
  - In the cycle after a req, imem_rdata plus its address + 4 are written to the queue tail, unless the response is marked dropped.
  - Push and pop in the same cycle are legal; count is unchanged.
- Queue:
  - 2-entry circular buffer with 1-bit read/write pointers that wrap.
  - if_valid = (count != 0).
  - The request rule guarantees the queue never overflows; overflow is an assertion failure.
- Redirect (br_taken=1 in cycle T):
  - In T: no req.
  - End of T: count <= 0, pointers reset, pc <= {br_target[ADDR_W-1:2],2'b00}.
  - Any response arriving in T (from a req in T-1) is dropped.
  - A pop occurring in T still counts as accepted by decode; all other entries are discarded.
  - T+1: imem_req=1 with imem_addr = target.
  - T+3: if_valid=1, if_instr = mem[target], if_pc_plus4 = target+4.
  - No old-path instruction appears on if_instr after cycle T.
  - br_taken on consecutive cycles: the last one wins.
- Latency and throughput:
  - Fetch-to-present is 2 cycles (req in N, valid in N+2).
  - Sustained rate is 1 instruction/cycle when if_ready=1 continuously.
- Reset mid-operation: immediate clear per the Reset bullet; the in-flight response is ignored.

Test Plan:
- Reset with RESET_PC=0x0040_0000:
  - Hold rst_n=0 for 3 cycles, then release → all outputs 0 during reset; imem_req=0 in cycle 0 after release.
  - Cycle 1: req addr 0x0040_0000. Cycle 3: if_valid=1, if_pc_plus4=0x0040_0004.
- Streaming, if_ready=1, memory returning word = address:
  - if_instr sequence is 0x0040_0000, 0x0040_0004, … at one per cycle, with no bubbles after the first.
- Backpressure, if_ready=0 for 5 cycles mid-stream:
  - if_instr stable; count ≤ 2; imem_req low once the queue is full.
  - On release, the sequence continues with no gap or duplicate.
- Redirect, br_taken at T with br_target=0x0000_0103:
  - req addr 0x0000_0100 at T+1; first valid at T+3 with if_pc_plus4=0x0000_0104.
  - No old-path words are presented after T.
- Simultaneous events, br_taken in the same cycle as a response arrival and a pop:
  - The popped entry is consumed once, the response is dropped, and the queue is empty at T+1.
- Wrap and mid-run reset:
  - RESET_PC=0xFFFF_FFF8 streams 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - Asserting rst_n=0 mid-stream clears if_valid the same cycle, and fetch restarts from RESET_PC.
